dic_tx_fmt: RTL and testbench
=============================

DIC_TX_FMT -- requirements
Module: dic_tx_fmt

Interface
REQ-001 SHALL have parameter SEP_CHAR, default 8'h3A (':'), byte emitted between minutes and seconds.
REQ-002 SHALL have parameter EOL_LF, default 1; 1 = emit LF (8'h0A) after CR, 0 = CR only.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port trig  input  1  one-cycle request to transmit the current time.
REQ-006 SHALL have ports dMtens, dMones, dStens, dSones  input  4 each  BCD digits to send.
REQ-007 SHALL have ports dspMtens, dspMones, dspStens, dspSones  input  1 each  digit-visible masks.
REQ-008 SHALL have port alarm_en  input  1  alarm-armed indicator.
REQ-009 SHALL have port tx_rdy  input  1  downstream UART transmitter can accept a byte.
REQ-010 SHALL have port tx_data  output  8  ASCII byte offered.
REQ-011 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-012 SHALL have port busy  output  1  a frame is in progress (state not IDLE).

Function
REQ-013 SHALL transfer a byte only on a cycle where tx_valid=1 and tx_rdy=1.
REQ-014 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_rdy=0.
REQ-015 SHALL use states IDLE, MT, MO, SEP, ST, SO, CR, LF (plus AL per REQ-027); each byte state advances only on transfer.
REQ-016 SHALL, in IDLE with trig=1, snapshot all digits, masks and alarm_en, then enter MT; tx_valid=1 on the next cycle.
REQ-017 SHALL emit frame order: MT, MO, SEP, ST, SO, [AL], CR, [LF], then return to IDLE.
REQ-018 SHALL encode a visible digit 0-9 as 8'h30+digit; values 10-15 as '?' (8'h3F).
REQ-019 SHALL emit space (8'h20) for a digit whose snapshotted mask is 0.
REQ-020 SHALL skip LF when EOL_LF=0 and go from CR directly to IDLE.
REQ-021 SHALL, on trig while busy=1, set a single pending flag; further triggers while pending is set are dropped.
REQ-022 SHALL, at the final transfer with pending=1, clear pending, re-snapshot the inputs and enter MT in the next cycle, without an intermediate IDLE cycle.
REQ-023 SHALL treat trig coincident with the final transfer as a pending request (same as REQ-022).
REQ-024 SHALL keep tx_valid=0 in IDLE; tx_data is don't-care there and SHALL be 8'h00.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and clear pending and the snapshot registers; outputs SHALL be tx_valid=0, tx_data=8'h00, busy=0, including when rst occurs mid-frame.
REQ-026 SHALL give rst priority over trig and tx_rdy in the same cycle.

Configuration
REQ-027 SHALL honour the macro DIC_TX_ALARM_FLAG_EN: when defined, state AL is inserted after SO and emits '@' (8'h40) if the snapshotted alarm_en=1, else space; when undefined, state AL and the alarm_en snapshot are absent, SO goes directly to CR, and alarm_en is unused.

Verification
REQ-028 The bench SHALL cover basic frame: digits 1,2,3,4, all masks 1, tx_rdy=1, trig pulse -> bytes 31 32 3A 33 34 0D 0A on 7 consecutive cycles starting one cycle after trig, then busy=0.
REQ-029 The bench SHALL cover backpressure: tx_rdy=0 for 5 cycles during MO -> tx_data=8'h32 held with tx_valid=1 for those cycles; frame otherwise unchanged.
REQ-030 The bench SHALL cover masks and invalid digits: dspStens=0, dspSones=0, dMtens=4'hC -> bytes 3F 32 3A 20 20 0D 0A.
REQ-031 The bench SHALL cover pending: two trigs during a frame, digits changed to 5,9,5,9 -> exactly one extra frame 35 39 3A 35 39 0D 0A immediately after the first frame.
REQ-032 The bench SHALL cover reset mid-frame: rst in state ST -> next cycle tx_valid=0, busy=0; a later trig sends a full new frame.
REQ-033 The bench SHALL cover alarm flag with DIC_TX_ALARM_FLAG_EN defined: alarm_en=1, digits 0,0,0,0 -> 30 30 3A 30 30 40 0D 0A.

Source files
------------

// File: rtl/dic_tx_fmt.sv
// dic_tx_fmt -- formats the current MM:SS time as an ASCII line for a UART.
//
// A one-cycle trig snapshots the four BCD digits, their visibility masks and
// (optionally) the alarm flag, then offers the frame one byte at a time on a
// valid/ready handshake:
//   MT MO SEP ST SO [AL] CR [LF]
// A trig that arrives while a frame is in progress is remembered in a single
// pending flag. The follow-up frame starts directly after the last byte, with
// no IDLE cycle in between.
//
// Optional feature macro: DIC_TX_ALARM_FLAG_EN
//   defined   -> an AL byte follows SO: '@' if the snapshotted alarm_en=1,
//                otherwise a space
//   undefined -> no AL byte, and alarm_en is ignored
//
// Ports:
//   clk                         clock, rising edge
//   rst                         synchronous active-high reset
//   trig                        one-cycle request to transmit the time
//   dMtens/dMones/dStens/dSones BCD digits (4 bits each)
//   dspMtens..dspSones          digit visible masks (0 -> space)
//   alarm_en                    alarm armed indicator
//   tx_rdy                      downstream can accept a byte
//   tx_data                     ASCII byte offered (8'h00 when idle)
//   tx_valid                    tx_data is valid
//   busy                        a frame is in progress
//
// State table:
//   IDLE | no frame in progress, tx_valid=0
//   MT   | offering the minutes tens digit
//   MO   | offering the minutes ones digit
//   SEP  | offering the separator character
//   ST   | offering the seconds tens digit
//   SO   | offering the seconds ones digit
//   AL   | offering the alarm flag (only with DIC_TX_ALARM_FLAG_EN)
//   CR   | offering carriage return
//   LF   | offering line feed (only when EOL_LF=1)
module dic_tx_fmt #(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter int         EOL_LF   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [3:0] dMtens,
  input  logic [3:0] dMones,
  input  logic [3:0] dStens,
  input  logic [3:0] dSones,
  input  logic       dspMtens,
  input  logic       dspMones,
  input  logic       dspStens,
  input  logic       dspSones,
  input  logic       alarm_en,
  input  logic       tx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    MT,
    MO,
    SEP,
    ST,
    SO,
`ifdef DIC_TX_ALARM_FLAG_EN
    AL,
`endif
    CR,
    LF
  } state_t;

  state_t     state;
  logic       pending;
  logic [3:0] snapMo, snapSt, snapSo;
  logic       visMo, visSt, visSo;
`ifdef DIC_TX_ALARM_FLAG_EN
  logic       snapAlarm;
`else
  logic       unusedAlarm;
  assign unusedAlarm = alarm_en;
`endif

  function automatic logic [7:0] digitChar(input logic [3:0] d, input logic vis);
    if (!vis)
      digitChar = 8'h20;
    else if (d > 4'd9)
      digitChar = 8'h3F;
    else
      digitChar = 8'h30 + {4'h0, d};
  endfunction

  logic xfer;
  logic lastByte;
  logic startFrame;

  assign xfer     = tx_valid && tx_rdy;
  assign lastByte = (state == LF) || ((state == CR) && (EOL_LF == 0));
  // A new frame starts from IDLE on trig, or back-to-back after the last
  // byte when a request is pending or arrives on that very cycle.
  assign startFrame = ((state == IDLE) && trig) ||
                      (xfer && lastByte && (pending || trig));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      snapMo   <= 4'h0;
      snapSt   <= 4'h0;
      snapSo   <= 4'h0;
      visMo    <= 1'b0;
      visSt    <= 1'b0;
      visSo    <= 1'b0;
`ifdef DIC_TX_ALARM_FLAG_EN
      snapAlarm <= 1'b0;
`endif
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else if (startFrame) begin
      // The minutes tens digit goes out immediately, so it needs no snapshot.
      snapMo   <= dMones;
      snapSt   <= dStens;
      snapSo   <= dSones;
      visMo    <= dspMones;
      visSt    <= dspStens;
      visSo    <= dspSones;
`ifdef DIC_TX_ALARM_FLAG_EN
      snapAlarm <= alarm_en;
`endif
      pending  <= 1'b0;
      state    <= MT;
      tx_data  <= digitChar(dMtens, dspMtens);
      tx_valid <= 1'b1;
      busy     <= 1'b1;
    end else if (state != IDLE) begin
      if (trig)
        pending <= 1'b1;
      if (xfer) begin
        case (state)
          MT: begin
            state   <= MO;
            tx_data <= digitChar(snapMo, visMo);
          end
          MO: begin
            state   <= SEP;
            tx_data <= SEP_CHAR;
          end
          SEP: begin
            state   <= ST;
            tx_data <= digitChar(snapSt, visSt);
          end
          ST: begin
            state   <= SO;
            tx_data <= digitChar(snapSo, visSo);
          end
`ifdef DIC_TX_ALARM_FLAG_EN
          SO: begin
            state   <= AL;
            tx_data <= snapAlarm ? 8'h40 : 8'h20;
          end
          AL: begin
            state   <= CR;
            tx_data <= 8'h0D;
          end
`else
          SO: begin
            state   <= CR;
            tx_data <= 8'h0D;
          end
`endif
          CR: begin
            if (EOL_LF != 0) begin
              state   <= LF;
              tx_data <= 8'h0A;
            end else begin
              state    <= IDLE;
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dic_tx_fmt.sv
// Self-checking bench for dic_tx_fmt. A reference model holds the expected
// bytes of the current frame in a queue. Each cycle the bench checks
// tx_valid, busy and tx_data against the head of that queue.
module tb_dic_tx_fmt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [3:0] dMtens = 4'h0, dMones = 4'h0, dStens = 4'h0, dSones = 4'h0;
  logic       dspMtens = 1'b1, dspMones = 1'b1, dspStens = 1'b1, dspSones = 1'b1;
  logic       alarm_en = 1'b0;
  logic       tx_rdy = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] expQ[$];
  logic       pend = 1'b0;

  dic_tx_fmt dut (
    .clk(clk), .rst(rst), .trig(trig),
    .dMtens(dMtens), .dMones(dMones), .dStens(dStens), .dSones(dSones),
    .dspMtens(dspMtens), .dspMones(dspMones), .dspStens(dspStens), .dspSones(dspSones),
    .alarm_en(alarm_en), .tx_rdy(tx_rdy),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d, input logic v);
    if (!v) return 8'h20;
    if (d > 9) return 8'h3F;
    return 8'h30 + {4'h0, d};
  endfunction

  // Build the expected line from the inputs present right now.
  task automatic loadFrame();
    expQ.delete();
    expQ.push_back(enc(dMtens, dspMtens));
    expQ.push_back(enc(dMones, dspMones));
    expQ.push_back(8'h3A);
    expQ.push_back(enc(dStens, dspStens));
    expQ.push_back(enc(dSones, dspSones));
`ifdef DIC_TX_ALARM_FLAG_EN
    expQ.push_back(alarm_en ? 8'h40 : 8'h20);
`endif
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
  endtask

  // Drive inputs for one clock, advance the model across that edge, then
  // compare the outputs on the following falling edge.
  task automatic step(input logic t, input logic r, input logic rdy);
    trig = t; rst = r; tx_rdy = rdy;
    if (r) begin
      expQ.delete();
      pend = 1'b0;
    end else if (expQ.size() == 0) begin
      if (t) loadFrame();
    end else if (rdy && expQ.size() == 1) begin
      if (pend || t) begin
        loadFrame();
        pend = 1'b0;
      end else begin
        expQ.delete();
      end
    end else begin
      if (rdy) void'(expQ.pop_front());
      if (t) pend = 1'b1;
    end
    @(negedge clk);
    trig = 1'b0;
    chk("valid", {7'h0, tx_valid}, {7'h0, expQ.size() != 0});
    chk("busy",  {7'h0, busy},     {7'h0, expQ.size() != 0});
    chk("data",  tx_data, (expQ.size() != 0) ? expQ[0] : 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && expQ.size() != 0; i++) step(1'b0, 1'b0, 1'b1);
    if (expQ.size() != 0) chk("drain_timeout", 8'h01, 8'h00);
  endtask

  task automatic setDigits(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    dMtens = a; dMones = b; dStens = c; dSones = d;
  endtask

  int nBytes;

  initial begin
    @(negedge clk);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("reset_data", tx_data, 8'h00);

    // basic frame 12:34
    setDigits(4'd1, 4'd2, 4'd3, 4'd4);
    step(1'b1, 1'b0, 1'b1);
    chk("basic_first", tx_data, 8'h31);
    nBytes = 1;
    while (busy && nBytes < 20) begin
      step(1'b0, 1'b0, 1'b1);
      if (busy) nBytes++;
    end
    chk("basic_len", nBytes[7:0], 8'd7);

    // backpressure on MO for 5 cycles
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("bp_hold", tx_data, 8'h32);
    end
    drain();

    // masks and invalid digit
    setDigits(4'hC, 4'd2, 4'd7, 4'd8);
    dspStens = 1'b0; dspSones = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    chk("mask_first", tx_data, 8'h3F);
    drain();
    dspStens = 1'b1; dspSones = 1'b1;

    // two trigs mid-frame, digits changed: exactly one follow-up frame
    setDigits(4'd1, 4'd2, 4'd3, 4'd4);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    setDigits(4'd5, 4'd9, 4'd5, 4'd9);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    nBytes = 4;
    while (busy && nBytes < 40) begin
      step(1'b0, 1'b0, 1'b1);
      if (busy) nBytes++;
    end
    chk("pend_len", nBytes[7:0], 8'd14);

    // reset while offering ST
    setDigits(4'd1, 4'd2, 4'd3, 4'd4);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_in_st", tx_data, 8'h33);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_mid_valid", {7'h0, tx_valid}, 8'h00);
    step(1'b1, 1'b0, 1'b1);
    drain();

`ifdef DIC_TX_ALARM_FLAG_EN
    setDigits(4'd0, 4'd0, 4'd0, 4'd0);
    alarm_en = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    chk("alarm_byte", tx_data, 8'h40);
    drain();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      setDigits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      dspMtens = 1'($urandom); dspMones = 1'($urandom);
      dspStens = 1'($urandom); dspSones = 1'($urandom);
      alarm_en = 1'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
